mac_periph_regfile: RTL and testbench
=====================================

# mac_periph_regfile

Peripheral-bus target of the MAC engine: it decodes HWPE peripheral requests from the cluster core and answers them with the same req/gnt/r_valid handshake. It holds the mandatory control registers, the generic registers and the job registers, and runs the job FSM that drives the engine's start and clear. It sits between the peripheral port of the MAC top wrapper and the MAC controller.

## Interface
- ID_WIDTH, 5, width of the request/response ID.
- N_CORES, 1, number of event lines.
- N_GENERIC, 8, generic R/W registers at 0x20.
- N_JOB, 8, job registers at 0x40.
- clk  in  1  clock.
- rstn  in  1  reset. Asynchronous, active-low.
- periph_req  in  1  request valid.
- periph_gnt  out  1  grant.
- periph_add  in  32  byte address. Only [7:2] is decoded.
- periph_wen  in  1  0 = write, 1 = read.
- periph_be  in  4  byte enables (writes only).
- periph_data  in  32  write data.
- periph_id  in  ID_WIDTH  request ID.
- periph_r_data  out  32  read data.
- periph_r_valid  out  1  response valid.
- periph_r_id  out  ID_WIDTH  echoed ID.
- start_o  out  1  one-cycle engine start pulse.
- clear_o  out  1  one-cycle soft-clear pulse.
- done_i  in  1  one-cycle job-done pulse from the engine.
- job_regs_o  out  N_JOB*32  job register contents, flat, register 0 in the LSBs.
- evt_o  out  N_CORES  one-cycle event pulse.

## Operation
- Register map:
  - 0x00 TRIGGER: write starts a job.
  - 0x04 ACQUIRE: read.
  - 0x08 FINISHED: read-only, 32-bit count of completed jobs.
  - 0x0C STATUS: read-only, 1 while RUNNING, else 0.
  - 0x10 RUNNING: read-only, 1 while in ACQUIRED or RUNNING.
  - 0x14 SOFTCLEAR: write clears.
  - 0x18 RESERVED: reads 0.
  - 0x1C SWEVT: write pulses evt_o.
  - 0x20–0x3C GENERIC0–7.
  - 0x40–0x5C JOB0–7: A, B, C, D address, NB_ITER, LEN_ITER, SHIFT_SIMPLEMUL, VECSTRIDE.
  - 0x60 and above: unmapped. Reads return 0, writes are dropped.
- FSM states: IDLE, ACQUIRED, RUNNING.
  - ACQUIRE read in IDLE: moves to ACQUIRED and returns 0. In any other state it returns 0xFFFFFFFF and the state is unchanged.
  - TRIGGER write in IDLE or ACQUIRED: moves to RUNNING and raises start_o on the next cycle. In RUNNING the write is ignored.
  - done_i in RUNNING: moves to IDLE, increments FINISHED (wraps at 2^32 to 0) and pulses evt_o[0] one cycle later.
  - done_i outside RUNNING is ignored.
- Writes to JOB registers in RUNNING are dropped but still get a response. GENERIC registers are writable in any state.
- Byte enables apply per byte to GENERIC and JOB writes. The data of TRIGGER, SOFTCLEAR and SWEVT writes is ignored.
- SOFTCLEAR write:
  - Next cycle: clear_o high, FSM to IDLE, JOB registers to 0, FINISHED to 0. GENERIC registers are kept.
  - Any job in flight is abandoned; no evt_o is issued for it.
- Simultaneous events:
  - done_i in the same cycle as an accepted TRIGGER while RUNNING: done wins; the trigger is ignored.
  - SOFTCLEAR in the same cycle as done_i: clear wins, FINISHED is 0, no event.

## Timing
- periph_gnt = periph_req, combinational; every request is accepted.
- Request accepted in cycle N gives periph_r_valid=1 in cycle N+1 with periph_r_id equal to the cycle-N ID.
  - Reads: periph_r_data holds the register value as of cycle N, before that cycle's update.
  - Writes: periph_r_data = 0.
  - Back-to-back requests produce one response per cycle.
- A write in cycle N is visible to a read issued in cycle N+1.
- TRIGGER accepted in N:
  - state = RUNNING from N+1; start_o high in N+1 only.
  - A STATUS read issued in N+1 returns 1 in N+2.
- done_i in N: state = IDLE in N+1, evt_o high in N+1, FINISHED updated in N+1.
- Reset values: all registers 0, state IDLE; periph_r_valid, periph_r_data, periph_r_id, start_o, clear_o, evt_o all 0.
- Reset asserted mid-job returns to IDLE with no pulses.

## Structure
- Package mac_periph_pkg holds:
  - register offset localparams (TRIGGER … VECSTRIDE);
  - the state enum (IDLE, ACQUIRED, RUNNING);
  - the ACQUIRE_FAIL constant 0xFFFFFFFF.
- One sub-module, mac_periph_be_reg: a 32-bit register with byte-enable write, a synchronous clear and asynchronous reset. It is instantiated for each GENERIC and JOB register.

## Test plan
- Write 0x40–0x58 with 0, 0, 0, 0, 1, 19, 1, then read them back → identical values, r_id echoed, r_valid exactly one cycle after each req.
- Write 0xAABBCCDD to GENERIC0 with be=4'b0101, then read → 0x00BB00DD.
- ACQUIRE read twice → 0 then 0xFFFFFFFF.
- Job lifecycle:
  - TRIGGER → start_o pulse one cycle later, STATUS reads 1.
  - JOB0 write during RUNNING → JOB0 unchanged.
  - done_i → evt_o pulse, STATUS 0, FINISHED 1.
- TRIGGER, then SOFTCLEAR while RUNNING → clear_o pulse, STATUS 0, JOB regs 0, FINISHED 0, no evt_o. A later done_i is ignored.
- done_i in the same cycle as a second TRIGGER → one start pulse total, FINISHED 1, state IDLE. A read of 0x60 → 0.

Source files
------------

// File: rtl/mac_periph_pkg.sv
// rtl/mac_periph_pkg.sv - register map, FSM state type and helpers for the MAC peripheral register file
// Contents:
//   REG_*        byte offsets of the control, generic and job registers
//   ACQUIRE_FAIL value returned by an ACQUIRE read when the engine is not idle
//   state_e      job FSM states
//   be_merge     byte-enable merge of write data into a 32-bit word
package mac_periph_pkg;

  localparam logic [7:0] REG_TRIGGER         = 8'h00;
  localparam logic [7:0] REG_ACQUIRE         = 8'h04;
  localparam logic [7:0] REG_FINISHED        = 8'h08;
  localparam logic [7:0] REG_STATUS          = 8'h0C;
  localparam logic [7:0] REG_RUNNING         = 8'h10;
  localparam logic [7:0] REG_SOFTCLEAR       = 8'h14;
  localparam logic [7:0] REG_RESERVED        = 8'h18;
  localparam logic [7:0] REG_SWEVT           = 8'h1C;
  localparam logic [7:0] REG_GENERIC0        = 8'h20;
  localparam logic [7:0] REG_JOB_A           = 8'h40;
  localparam logic [7:0] REG_JOB_B           = 8'h44;
  localparam logic [7:0] REG_JOB_C           = 8'h48;
  localparam logic [7:0] REG_JOB_D           = 8'h4C;
  localparam logic [7:0] REG_NB_ITER         = 8'h50;
  localparam logic [7:0] REG_LEN_ITER        = 8'h54;
  localparam logic [7:0] REG_SHIFT_SIMPLEMUL = 8'h58;
  localparam logic [7:0] REG_VECSTRIDE       = 8'h5C;

  localparam logic [31:0] ACQUIRE_FAIL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRED = 2'd1,
    RUNNING  = 2'd2
  } state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_periph_be_reg.sv
// rtl/mac_periph_be_reg.sv - 32-bit register with byte-enable write and synchronous clear
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   clear      synchronous clear to 0, takes priority over a write
//   we, be     write strobe and per-byte enables
//   wdata      write data
//   q          register contents
module mac_periph_be_reg
  import mac_periph_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (we) begin
      q <= be_merge(q, wdata, be);
    end
  end

endmodule

// File: rtl/mac_periph_regfile.sv
// rtl/mac_periph_regfile.sv - peripheral-bus register file and job FSM of the MAC engine
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   periph_req/gnt/add/wen/be/data/id  request side (wen: 0 = write, 1 = read)
//   periph_r_data/r_valid/r_id    response side, one cycle after each request
//   start_o, clear_o              one-cycle engine start and soft-clear pulses
//   done_i                        one-cycle job-done pulse from the engine
//   job_regs_o                    flat job registers, register 0 in the LSBs
//   evt_o                         one-cycle event pulses
module mac_periph_regfile
  import mac_periph_pkg::*;
#(
  parameter int ID_WIDTH  = 5,
  parameter int N_CORES   = 1,
  parameter int N_GENERIC = 8,
  parameter int N_JOB     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  periph_req,
  output logic                  periph_gnt,
  input  logic [31:0]           periph_add,
  input  logic                  periph_wen,
  input  logic [3:0]            periph_be,
  input  logic [31:0]           periph_data,
  input  logic [ID_WIDTH-1:0]   periph_id,
  output logic [31:0]           periph_r_data,
  output logic                  periph_r_valid,
  output logic [ID_WIDTH-1:0]   periph_r_id,
  output logic                  start_o,
  output logic                  clear_o,
  input  logic                  done_i,
  output logic [N_JOB*32-1:0]   job_regs_o,
  output logic [N_CORES-1:0]    evt_o
);

  localparam int GEN_IDX = int'(REG_GENERIC0[7:2]);
  localparam int JOB_IDX = int'(REG_JOB_A[7:2]);

  state_e state_q, state_d;

  logic [5:0]  idx;
  logic        wr, rd;
  logic        trig_wr, clr_wr, swevt_wr, acq_rd;
  logic        start_d, done_evt;
  logic [N_CORES-1:0] evt_d;
  logic [31:0] finished_q;
  logic [31:0] rdata_d;

  logic [N_GENERIC-1:0][31:0] generic_q;
  logic [N_JOB-1:0][31:0]     job_q;
  logic [N_GENERIC-1:0]       generic_we;
  logic [N_JOB-1:0]           job_we;

  logic unused_add;
  assign unused_add = ^{periph_add[31:8], periph_add[1:0]};

  assign periph_gnt = periph_req;
  assign idx        = periph_add[7:2];
  assign wr         = periph_req & ~periph_wen;
  assign rd         = periph_req &  periph_wen;
  assign trig_wr    = wr && (idx == REG_TRIGGER[7:2]);
  assign clr_wr     = wr && (idx == REG_SOFTCLEAR[7:2]);
  assign swevt_wr   = wr && (idx == REG_SWEVT[7:2]);
  assign acq_rd     = rd && (idx == REG_ACQUIRE[7:2]);

  // Generic registers are always writable; job registers are frozen while
  // the engine consumes them and wiped by a soft clear.
  for (genvar g = 0; g < N_GENERIC; g++) begin : gen_generic
    assign generic_we[g] = wr && (int'(idx) == GEN_IDX + g);
    mac_periph_be_reg u_reg (
      .clk   (clk),
      .rstn  (rstn),
      .clear (1'b0),
      .we    (generic_we[g]),
      .be    (periph_be),
      .wdata (periph_data),
      .q     (generic_q[g])
    );
  end

  for (genvar j = 0; j < N_JOB; j++) begin : gen_job
    assign job_we[j] = wr && (state_q != RUNNING) && (int'(idx) == JOB_IDX + j);
    mac_periph_be_reg u_reg (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clr_wr),
      .we    (job_we[j]),
      .be    (periph_be),
      .wdata (periph_data),
      .q     (job_q[j])
    );
  end

  assign job_regs_o = job_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Soft clear overrides everything, including a coincident done; a done
  // while RUNNING wins over a trigger simply because triggers are ignored there.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    done_evt = 1'b0;
    if (clr_wr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (acq_rd) begin
            state_d = ACQUIRED;
          end else if (trig_wr) begin
            state_d = RUNNING;
            start_d = 1'b1;
          end
        end
        ACQUIRED: begin
          if (trig_wr) begin
            state_d = RUNNING;
            start_d = 1'b1;
          end
        end
        RUNNING: begin
          if (done_i) begin
            state_d  = IDLE;
            done_evt = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    evt_d    = {N_CORES{swevt_wr}};
    evt_d[0] = evt_d[0] | done_evt;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (idx)
        REG_ACQUIRE[7:2]:  rdata_d = (state_q == IDLE) ? 32'd0 : ACQUIRE_FAIL;
        REG_FINISHED[7:2]: rdata_d = finished_q;
        REG_STATUS[7:2]:   rdata_d = {31'd0, state_q == RUNNING};
        REG_RUNNING[7:2]:  rdata_d = {31'd0, state_q != IDLE};
        default: begin
          for (int i = 0; i < N_GENERIC; i++) begin
            if (int'(idx) == GEN_IDX + i) rdata_d = generic_q[i];
          end
          for (int i = 0; i < N_JOB; i++) begin
            if (int'(idx) == JOB_IDX + i) rdata_d = job_q[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      periph_r_valid <= 1'b0;
      periph_r_data  <= '0;
      periph_r_id    <= '0;
      start_o        <= 1'b0;
      clear_o        <= 1'b0;
      evt_o          <= '0;
      finished_q     <= '0;
    end else begin
      periph_r_valid <= periph_req;
      periph_r_data  <= rdata_d;
      periph_r_id    <= periph_req ? periph_id : '0;
      start_o        <= start_d;
      clear_o        <= clr_wr;
      evt_o          <= evt_d;
      if (clr_wr)        finished_q <= '0;
      else if (done_evt) finished_q <= finished_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mac_periph_regfile.sv
// tb/tb_mac_periph_regfile.sv - directed self-checking bench for mac_periph_regfile
module tb_mac_periph_regfile;

  logic          clk;
  logic          rstn;
  logic          periph_req;
  logic          periph_gnt;
  logic [31:0]   periph_add;
  logic          periph_wen;
  logic [3:0]    periph_be;
  logic [31:0]   periph_data;
  logic [4:0]    periph_id;
  logic [31:0]   periph_r_data;
  logic          periph_r_valid;
  logic [4:0]    periph_r_id;
  logic          start_o;
  logic          clear_o;
  logic          done_i;
  logic [255:0]  job_regs_o;
  logic [0:0]    evt_o;

  int checks = 0;
  int errors = 0;

  mac_periph_regfile #(
    .ID_WIDTH  (5),
    .N_CORES   (1),
    .N_GENERIC (8),
    .N_JOB     (8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .periph_req     (periph_req),
    .periph_gnt     (periph_gnt),
    .periph_add     (periph_add),
    .periph_wen     (periph_wen),
    .periph_be      (periph_be),
    .periph_data    (periph_data),
    .periph_id      (periph_id),
    .periph_r_data  (periph_r_data),
    .periph_r_valid (periph_r_valid),
    .periph_r_id    (periph_r_id),
    .start_o        (start_o),
    .clear_o        (clear_o),
    .done_i         (done_i),
    .job_regs_o     (job_regs_o),
    .evt_o          (evt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; request is accepted on the next rising edge and
  // the response is sampled at the falling edge after it.
  task automatic xfer(input logic wen, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] data, input logic [4:0] id, output logic [31:0] rdata);
    periph_req  = 1'b1;
    periph_wen  = wen;
    periph_add  = addr;
    periph_be   = be;
    periph_data = data;
    periph_id   = id;
    #1;
    check("gnt", 32'(periph_gnt), 32'd1);
    @(negedge clk);
    check("r_valid", 32'(periph_r_valid), 32'd1);
    check("r_id", 32'(periph_r_id), 32'(id));
    rdata = periph_r_data;
    periph_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be, input logic [4:0] id);
    logic [31:0] r;
    xfer(1'b0, addr, be, data, id, r);
    check("wr_rdata", r, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [4:0] id, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b1, addr, 4'h0, 32'd0, id, r);
    check(tag, r, exp);
  endtask

  task automatic idle_cycle();
    periph_req = 1'b0;
    @(negedge clk);
    check("r_valid_idle", 32'(periph_r_valid), 32'd0);
  endtask

  logic [31:0] job_vals [7];

  initial begin
    job_vals = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd19, 32'd1};
    rstn        = 1'b0;
    periph_req  = 1'b0;
    periph_add  = '0;
    periph_wen  = 1'b0;
    periph_be   = '0;
    periph_data = '0;
    periph_id   = '0;
    done_i      = 1'b0;

    #1;
    check("rst_r_valid", 32'(periph_r_valid), 32'd0);
    check("rst_r_data", periph_r_data, 32'd0);
    check("rst_r_id", 32'(periph_r_id), 32'd0);
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_clear", 32'(clear_o), 32'd0);
    check("rst_evt", 32'(evt_o), 32'd0);
    check("rst_job_or", 32'(|job_regs_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    rd("rst_status", 32'h0C, 5'd1, 32'd0);
    rd("rst_finished", 32'h08, 5'd2, 32'd0);
    rd("rst_generic0", 32'h20, 5'd3, 32'd0);

    // Job registers: back-to-back writes then read-back.
    for (int i = 0; i < 7; i++) wr(32'h40 + 32'(i * 4), job_vals[i], 4'hF, 5'(i + 4));
    idle_cycle();
    for (int i = 0; i < 7; i++) rd("job_readback", 32'h40 + 32'(i * 4), 5'(i + 16), job_vals[i]);
    idle_cycle();
    check("job_regs_o_5", job_regs_o[5*32 +: 32], 32'd19);
    check("job_regs_o_6", job_regs_o[6*32 +: 32], 32'd1);

    // Byte-enabled generic write.
    wr(32'h20, 32'hAABBCCDD, 4'b0101, 5'd30);
    rd("generic0_be", 32'h20, 5'd31, 32'h00BB00DD);

    // Software event.
    wr(32'h1C, 32'h0, 4'hF, 5'd5);
    check("swevt_evt", 32'(evt_o), 32'd1);
    idle_cycle();
    check("swevt_evt_end", 32'(evt_o), 32'd0);

    // Acquire.
    rd("acquire_first", 32'h04, 5'd6, 32'd0);
    rd("running_acq", 32'h10, 5'd7, 32'd1);
    rd("status_acq", 32'h0C, 5'd8, 32'd0);
    rd("acquire_second", 32'h04, 5'd9, 32'hFFFFFFFF);

    // Job lifecycle.
    wr(32'h00, 32'h1234, 4'hF, 5'd10);
    check("start_pulse", 32'(start_o), 32'd1);
    rd("status_running", 32'h0C, 5'd11, 32'd1);
    check("start_end", 32'(start_o), 32'd0);
    wr(32'h40, 32'h12345678, 4'hF, 5'd12);
    rd("job0_locked", 32'h40, 5'd13, 32'd0);
    wr(32'h24, 32'h5A5A5A5A, 4'hF, 5'd14);
    rd("generic1_running", 32'h24, 5'd15, 32'h5A5A5A5A);
    rd("acquire_running", 32'h04, 5'd16, 32'hFFFFFFFF);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    check("done_evt", 32'(evt_o), 32'd1);
    rd("status_done", 32'h0C, 5'd17, 32'd0);
    check("done_evt_end", 32'(evt_o), 32'd0);
    rd("finished_1", 32'h08, 5'd18, 32'd1);

    // Soft clear during a job, coinciding with done.
    wr(32'h00, 32'h0, 4'hF, 5'd19);
    check("start_pulse2", 32'(start_o), 32'd1);
    done_i = 1'b1;
    wr(32'h14, 32'hFFFFFFFF, 4'hF, 5'd20);
    done_i = 1'b0;
    check("clear_pulse", 32'(clear_o), 32'd1);
    check("clear_no_evt", 32'(evt_o), 32'd0);
    rd("status_clear", 32'h0C, 5'd21, 32'd0);
    check("clear_end", 32'(clear_o), 32'd0);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    check("late_done_no_evt", 32'(evt_o), 32'd0);
    rd("finished_clear", 32'h08, 5'd22, 32'd0);
    rd("job4_clear", 32'h50, 5'd23, 32'd0);
    check("job_regs_o_clear", 32'(|job_regs_o), 32'd0);
    rd("generic0_kept", 32'h20, 5'd24, 32'h00BB00DD);
    rd("running_clear", 32'h10, 5'd25, 32'd0);

    // done_i together with a second trigger while RUNNING.
    wr(32'h00, 32'h0, 4'hF, 5'd26);
    check("start_pulse3", 32'(start_o), 32'd1);
    done_i = 1'b1;
    wr(32'h00, 32'h0, 4'hF, 5'd27);
    done_i = 1'b0;
    check("dup_trig_no_start", 32'(start_o), 32'd0);
    check("dup_trig_evt", 32'(evt_o), 32'd1);
    rd("status_dup", 32'h0C, 5'd28, 32'd0);
    check("dup_no_start_later", 32'(start_o), 32'd0);
    rd("finished_dup", 32'h08, 5'd29, 32'd1);
    rd("running_dup", 32'h10, 5'd0, 32'd0);

    // Unmapped and reserved space.
    rd("unmapped_60", 32'h60, 5'd1, 32'd0);
    wr(32'h60, 32'hCAFEF00D, 4'hF, 5'd2);
    rd("unmapped_60_after_wr", 32'h60, 5'd3, 32'd0);
    rd("reserved_18", 32'h18, 5'd4, 32'd0);
    rd("generic0_unmapped", 32'h20, 5'd5, 32'h00BB00DD);

    // Reset in the middle of a job.
    wr(32'h00, 32'h0, 4'hF, 5'd6);
    check("start_pulse4", 32'(start_o), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_start", 32'(start_o), 32'd0);
    check("midrst_r_valid", 32'(periph_r_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle_cycle();
    check("midrst_no_start", 32'(start_o), 32'd0);
    check("midrst_no_evt", 32'(evt_o), 32'd0);
    rd("midrst_status", 32'h0C, 5'd7, 32'd0);
    rd("midrst_acquire", 32'h04, 5'd8, 32'd0);
    rd("midrst_generic0", 32'h20, 5'd9, 32'd0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
